// File: rtl/seq_detector_pkg.sv
// Shared defaults for the serial pattern detector.
// Parameter defaults live here so every instantiating block uses the same values.
package seq_detector_pkg;

    localparam int         DEFAULT_PAT_LEN = 4;
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;
    localparam int         MAX_PAT_LEN     = 16;
    localparam int         FILL_W          = 5;

endpackage

// File: rtl/seq_detector.sv
// Serial bit-pattern detector: pulses det for one cycle when the most recent
// PAT_LEN sampled bits equal PATTERN (first-received bit is the pattern MSB).
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int                     PAT_LEN = DEFAULT_PAT_LEN,
    parameter logic [MAX_PAT_LEN-1:0] PATTERN = 16'(DEFAULT_PATTERN),
    parameter bit                     OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic det
);

    if (PAT_LEN < 2 || PAT_LEN > MAX_PAT_LEN) begin : g_bad_pat_len
        $error("seq_detector: PAT_LEN must be in 2..16");
    end

    localparam logic [PAT_LEN-1:0] PAT       = PATTERN[PAT_LEN-1:0];
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
    logic               det_q, det_d;
    logic               match;

    // A match only counts once fill shows PAT_LEN genuine post-reset bits,
    // so patterns with leading zeros cannot fire on the cleared history.
    assign match = (hist_d == PAT) && (fill_inc == FILL_FULL);

    always_comb begin
        hist_d   = (hist_q << 1) | {{(PAT_LEN-1){1'b0}}, in};
        fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 5'd1;
        fill_d   = (!OVERLAP && match) ? '0 : fill_inc;
        det_d    = match;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            det_q  <= det_d;
        end
    end

    assign det = det_q;

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: three configurations share one input
// stream and are compared against a bit-queue reference model.
module tb_seq_detector;
    import seq_detector_pkg::*;

    logic clk;
    logic rst;
    logic din;
    logic det_ovl, det_novl, det_zero;

    int checks   = 0;
    int failures = 0;
    int p_ovl, p_novl, p_zero;

    bit q_ovl[$];
    bit q_novl[$];
    bit q_zero[$];

    seq_detector #(.PAT_LEN(4), .PATTERN(16'h000B), .OVERLAP(1'b1)) u_ovl (
        .clk(clk), .rst(rst), .in(din), .det(det_ovl)
    );

    seq_detector #(.PAT_LEN(4), .PATTERN(16'h000B), .OVERLAP(1'b0)) u_novl (
        .clk(clk), .rst(rst), .in(din), .det(det_novl)
    );

    seq_detector #(.PAT_LEN(3), .PATTERN(16'h0000), .OVERLAP(1'b1)) u_zero (
        .clk(clk), .rst(rst), .in(din), .det(det_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", tag, actual, expected, $time);
        end
    endtask

    // True when the newest len received bits, oldest first, spell pat[len-1:0].
    function automatic bit modelMatch(input bit q[$], input int len, input logic [15:0] pat);
        if (q.size() < len) return 1'b0;
        for (int i = 0; i < len; i++) begin
            if (q[q.size() - len + i] != pat[len-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelReset();
        q_ovl.delete();
        q_novl.delete();
        q_zero.delete();
    endtask

    task automatic applyStimulus(input logic b);
        bit e_ovl, e_novl, e_zero;
        din = b;
        @(posedge clk);
        #1;
        q_ovl.push_back(b);
        q_novl.push_back(b);
        q_zero.push_back(b);
        if (q_ovl.size() > 16) void'(q_ovl.pop_front());
        if (q_zero.size() > 16) void'(q_zero.pop_front());
        e_ovl  = modelMatch(q_ovl, 4, 16'h000B);
        e_novl = modelMatch(q_novl, 4, 16'h000B);
        e_zero = modelMatch(q_zero, 3, 16'h0000);
        // Without overlap, a match consumes the whole history.
        if (e_novl) q_novl.delete();
        else if (q_novl.size() > 16) void'(q_novl.pop_front());
        checkOutput("det_ovl", 32'(det_ovl), 32'(e_ovl));
        checkOutput("det_novl", 32'(det_novl), 32'(e_novl));
        checkOutput("det_zero", 32'(det_zero), 32'(e_zero));
        p_ovl  += int'(det_ovl);
        p_novl += int'(det_novl);
        p_zero += int'(det_zero);
    endtask

    task automatic runSeq(input logic [31:0] bits, input int n);
        p_ovl  = 0;
        p_novl = 0;
        p_zero = 0;
        for (int i = n - 1; i >= 0; i--) applyStimulus(bits[i]);
    endtask

    task automatic resetPulse(input int cycles);
        #3;
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_async_ovl", 32'(det_ovl), 32'd0);
        checkOutput("rst_async_novl", 32'(det_novl), 32'd0);
        checkOutput("rst_async_zero", 32'(det_zero), 32'd0);
        for (int i = 0; i < cycles; i++) begin
            din = ~din;
            @(posedge clk);
            #1;
            checkOutput("rst_hold_ovl", 32'(det_ovl), 32'd0);
            checkOutput("rst_hold_zero", 32'(det_zero), 32'd0);
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        din = 1'b0;
        modelReset();
        #1;
        checkOutput("reset_t0", 32'(det_ovl), 32'd0);
        for (int i = 0; i < 4; i++) begin
            din = ~din;
            @(posedge clk);
            #1;
            checkOutput("reset_hold_ovl", 32'(det_ovl), 32'd0);
            checkOutput("reset_hold_novl", 32'(det_novl), 32'd0);
            checkOutput("reset_hold_zero", 32'(det_zero), 32'd0);
        end
        rst = 1'b1;

        runSeq(32'b1011, 4);
        checkOutput("basic_pulses", 32'(p_ovl), 32'd1);

        resetPulse(2);
        runSeq(32'b010110101, 9);
        checkOutput("stream9_pulses", 32'(p_ovl), 32'd1);

        resetPulse(1);
        runSeq(32'b1010101, 7);
        checkOutput("alt_pulses", 32'(p_ovl), 32'd0);

        resetPulse(1);
        runSeq(32'b1011011, 7);
        checkOutput("overlap_pulses", 32'(p_ovl), 32'd2);
        checkOutput("no_overlap_pulses", 32'(p_novl), 32'd1);

        resetPulse(1);
        runSeq(32'b11011, 5);
        checkOutput("prefix_pulses", 32'(p_ovl), 32'd1);

        resetPulse(1);
        runSeq(32'b101, 3);
        resetPulse(1);
        runSeq(32'b1, 1);
        checkOutput("straddle_pulses", 32'(p_ovl), 32'd0);
        runSeq(32'b1011, 4);
        checkOutput("after_straddle_pulses", 32'(p_ovl), 32'd1);

        resetPulse(1);
        runSeq(32'b00, 2);
        checkOutput("zero_early_pulses", 32'(p_zero), 32'd0);
        runSeq(32'b0, 1);
        checkOutput("zero_third_pulses", 32'(p_zero), 32'd1);
        runSeq(32'b00, 2);
        checkOutput("zero_b2b_pulses", 32'(p_zero), 32'd2);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 39) == 0) resetPulse(int'($urandom_range(1, 3)));
            else applyStimulus(1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
